fdm_fuse_readback: RTL

FDM_FUSE_READBACK -- requirements
Module: fdm_fuse_readback

---
 rtl/fuse_lut_pkg.sv | 38 +++
 rtl/fdm_fuse_readback_if.sv | 26 ++
 rtl/fdm_ack_timer.sv | 40 ++++
 rtl/fdm_fuse_readback.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/fuse_lut_pkg.sv
// Shared types for the fuse LUT walkers: LUT entry layout, readback FSM
// states, wait-counter sizing and the readback status bundle.
package fuse_lut_pkg;

  localparam int LUT_ENTRIES     = 64;
  localparam int IDX_W           = 6;
  localparam int TIMEOUT_DEFAULT = 255;

  // Wait counter must be able to hold the largest reload value (TIMEOUT-1).
  function automatic int wait_cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  localparam int WAIT_CNT_W = wait_cnt_width(TIMEOUT_DEFAULT);

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] source_address;
    logic [31:0] dest_address;
  } fuse_lut_element_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    READ,
    WRITE,
    NEXT,
    DONE
  } rb_state_e;

  typedef struct packed {
    logic             busy;
    logic             done;
    logic             err;
    logic [IDX_W-1:0] err_idx;
  } rb_status_t;

endpackage

// File: rtl/fdm_fuse_readback_if.sv
// Register-side read channel and fuse-side write channel of the readback walker.
interface fdm_fuse_readback_if;

  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack;
  logic        rd_err;
  logic [31:0] rd_data;

  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_ack;
  logic        wr_err;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_ack, rd_err, rd_data, wr_ack, wr_err
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_ack, rd_err, rd_data, wr_ack, wr_err
  );

endinterface

// File: rtl/fdm_ack_timer.sv
// Down-counting ack watchdog: load arms it with TIMEOUT-1, every enabled
// cycle without a reload counts down, expired flags the last allowed cycle.
module fdm_ack_timer #(
  parameter int TIMEOUT = 255,
  parameter int W       = fuse_lut_pkg::wait_cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] RELOAD = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Reload has priority so a READ->WRITE hand-over restarts the full window.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = RELOAD;
    end else if (enable && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/fdm_fuse_readback.sv
// Fuse readback walker: for every LUT entry with a non-zero mask, read the
// destination register and write the masked value back to the fuse source.
module fdm_fuse_readback
  import fuse_lut_pkg::*;
#(
  parameter int ENTRIES = LUT_ENTRIES,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  output logic [5:0]                 lut_idx,
  input  fuse_lut_element_t          lut_entry,
  fdm_fuse_readback_if.master        bus,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [5:0]                 err_idx
);

  rb_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [31:0]      rd_addr_q, rd_addr_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [31:0]      mask_q, mask_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             err_q, err_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;

  logic             tmr_load;
  logic             tmr_enable;
  logic             tmr_expired;
  rb_status_t       status;

  fdm_ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .enable  (tmr_enable),
    .expired (tmr_expired)
  );

  assign tmr_enable = (state_q == READ) || (state_q == WRITE);

  // Next-state logic; abort always wins, and any error ends the walk in DONE.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    mask_d    = mask_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    tmr_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FETCH;
          idx_d     = '0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      FETCH: begin
        if (abort) begin
          state_d = DONE;
        end else if (lut_entry.mask == '0) begin
          state_d = NEXT;
        end else begin
          rd_addr_d = lut_entry.dest_address;
          wr_addr_d = lut_entry.source_address;
          mask_d    = lut_entry.mask;
          tmr_load  = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        if (abort) begin
          // A coincident good ack is taken, but its write never goes out.
          if (bus.rd_ack && !bus.rd_err) begin
            wr_data_d = bus.rd_data & mask_q;
          end
          state_d = DONE;
        end else if (bus.rd_ack) begin
          if (bus.rd_err) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = DONE;
          end else begin
            wr_data_d = bus.rd_data & mask_q;
            tmr_load  = 1'b1;
            state_d   = WRITE;
          end
        end else if (tmr_expired) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = DONE;
        end
      end
      WRITE: begin
        if (abort) begin
          state_d = DONE;
        end else if (bus.wr_ack) begin
          if (bus.wr_err) begin
            err_d     = 1'b1;
            err_idx_d = idx_q;
            state_d   = DONE;
          end else begin
            state_d = NEXT;
          end
        end else if (tmr_expired) begin
          err_d     = 1'b1;
          err_idx_d = idx_q;
          state_d   = DONE;
        end
      end
      NEXT: begin
        if (abort || (idx_q == IDX_W'(ENTRIES - 1))) begin
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = FETCH;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears every request immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      mask_q    <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      mask_q    <= mask_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign status = '{busy:    (state_q != IDLE),
                    done:    (state_q == DONE),
                    err:     err_q,
                    err_idx: err_idx_q};

  assign bus.rd_req  = (state_q == READ);
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_req  = (state_q == WRITE);
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  assign lut_idx = idx_q;
  assign busy    = status.busy;
  assign done    = status.done;
  assign err     = status.err;
  assign err_idx = status.err_idx;

endmodule
